// File: rtl/adder_tree_acc_ctrl.sv
// adder_tree_acc_ctrl: sums 16-lane vectors through adder_tree_16 and
// accumulates cfg_groups vectors plus a bias into one saturated result.
//
// Ports:
//   clk, rst              clock, async active-high reset
//   cfg_groups, cfg_bias  vectors per result (0 means 1) and signed bias,
//                         both sampled on the first beat of a group
//   in_valid/in_ready     input handshake, in_data = 16 signed lanes
//   out_valid/out_ready   result handshake, out_data signed, out_sat clipped
//   busy                  group in progress or result pending
//
// Optional feature: ADDER_ACC_RELU_EN clamps negative results to zero
// after saturation. out_sat still reports the pre-ReLU clip.

module adder_tree_16 #(
    parameter int WIDTH = 32
) (
    input  logic [16*WIDTH-1:0] in_data,
    output logic [WIDTH-1:0]    sum
);

    logic [WIDTH-1:0] l0 [16];
    logic [WIDTH-1:0] l1 [8];
    logic [WIDTH-1:0] l2 [4];
    logic [WIDTH-1:0] l3 [2];

    // Each level wraps modulo 2**WIDTH, like a plain WIDTH-bit tree.
    always_comb begin
        for (int i = 0; i < 16; i++) l0[i] = in_data[i*WIDTH +: WIDTH];
        for (int i = 0; i < 8; i++)  l1[i] = l0[2*i] + l0[2*i+1];
        for (int i = 0; i < 4; i++)  l2[i] = l1[2*i] + l1[2*i+1];
        for (int i = 0; i < 2; i++)  l3[i] = l2[2*i] + l2[2*i+1];
        sum = l3[0] + l3[1];
    end

endmodule

module adder_tree_acc_ctrl #(
    parameter int WIDTH = 32,
    parameter int GRP_W = 8,
    parameter int ACC_W = WIDTH + 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [GRP_W-1:0]    cfg_groups,
    input  logic [WIDTH-1:0]    cfg_bias,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [16*WIDTH-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_data,
    output logic                out_sat,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t           state;
    state_t           nxt;

    logic [GRP_W-1:0] cnt;
    logic [GRP_W-1:0] groups;
    logic [WIDTH-1:0] bias;
    logic [ACC_W-1:0] acc;

    logic [WIDTH-1:0] s1;
    logic             s1_vld;
    logic             s1_last;
    logic             s1_first;

    logic [WIDTH-1:0] tree_sum;
    logic             fire;
    logic [GRP_W-1:0] g_eff;
    logic [GRP_W:0]   cnt_inc;

    logic [ACC_W-1:0]   acc_base;
    logic [ACC_W-1:0]   acc_next;
    logic [ACC_W-WIDTH:0] acc_hi;
    logic               clip;
    logic [WIDTH-1:0]   sat_val;
    logic [WIDTH-1:0]   res_val;

    adder_tree_16 #(.WIDTH(WIDTH)) u_tree (
        .in_data (in_data),
        .sum     (tree_sum)
    );

    // The last beat's partial sum blocks new input until its result
    // has been handed off, so groups never overlap.
    assign in_ready = !out_valid && !(s1_vld && s1_last);
    assign fire     = in_valid && in_ready;
    assign busy     = (state != IDLE) || s1_vld;

    assign g_eff    = (cfg_groups == '0) ? GRP_W'(1) : cfg_groups;
    assign cnt_inc  = {1'b0, cnt} + {{GRP_W{1'b0}}, 1'b1};

    always_comb begin
        acc_base = s1_first
                 ? {{(ACC_W-WIDTH){bias[WIDTH-1]}}, bias}
                 : acc;
        acc_next = acc_base + {{(ACC_W-WIDTH){s1[WIDTH-1]}}, s1};
    end

    // In range iff the bits above the WIDTH-1 sign bit all match it.
    always_comb begin
        acc_hi  = acc_next[ACC_W-1:WIDTH-1];
        clip    = !((&acc_hi) || !(|acc_hi));
        sat_val = acc_next[WIDTH-1:0];
        if (clip) begin
            sat_val = acc_next[ACC_W-1]
                    ? {1'b1, {(WIDTH-1){1'b0}}}
                    : {1'b0, {(WIDTH-1){1'b1}}};
        end
`ifdef ADDER_ACC_RELU_EN
        res_val = sat_val[WIDTH-1] ? '0 : sat_val;
`else
        res_val = sat_val;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (fire) nxt = ACC;
            ACC:     if (s1_vld && s1_last) nxt = OUT;
            OUT:     if (out_valid && out_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            groups    <= '0;
            bias      <= '0;
            acc       <= '0;
            s1        <= '0;
            s1_vld    <= 1'b0;
            s1_last   <= 1'b0;
            s1_first  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            s1_vld <= fire;
            if (fire) begin
                s1       <= tree_sum;
                s1_first <= (state == IDLE);
                if (state == IDLE) begin
                    groups  <= g_eff;
                    bias    <= cfg_bias;
                    cnt     <= GRP_W'(1);
                    s1_last <= (g_eff == GRP_W'(1));
                end else begin
                    cnt     <= cnt_inc[GRP_W-1:0];
                    s1_last <= (cnt_inc == {1'b0, groups});
                end
            end
            if (s1_vld) begin
                acc <= acc_next;
                if (s1_last) begin
                    out_data  <= res_val;
                    out_sat   <= clip;
                    out_valid <= 1'b1;
                    cnt       <= '0;
                end
            end
            if (out_valid && out_ready) out_valid <= 1'b0;
        end
    end

endmodule
